counter_ext: RTL and testbench
==============================

Name: counter_ext

Overview:
- Parametrised successor to the basic free-running up counter used across the test suite.
- Adds enable, up/down direction, synchronous clear and load, and a programmable modulus.
- Offers a selectable wrap or saturate mode, plus a registered terminal-count pulse and a sticky overflow flag.
- Serves as a reusable timer/event-counter primitive and as a defparam/parameter-override stress target.

Parameters:
- WIDTH, 8: counter width in bits; must be >= 1.
- MAX_VAL, 255: highest legal count (modulus = MAX_VAL+1); must be <= 2**WIDTH-1.
- RESET_VAL, 0: count value after reset and after clr; must be <= MAX_VAL.
- STEP, 1: increment/decrement per enabled cycle; must satisfy 1 <= STEP <= MAX_VAL.
- SATURATE, 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable, sampled on posedge clk
- up  input  1  direction: 1 = count up, 0 = count down
- clr  input  1  synchronous clear to RESET_VAL; also clears ovf
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load; clamped to MAX_VAL if larger
- count  output  WIDTH  current count, registered
- tc  output  1  registered one-cycle pulse on a boundary crossing
- ovf  output  1  sticky flag: a boundary was crossed since the last clr/reset

Behaviour:
- Reset: rst_n low asynchronously forces count=RESET_VAL, tc=0, ovf=0, regardless of clk.
  - Release is synchronous; the first update occurs on the first posedge with rst_n high.
  - Reset asserted mid-count overrides everything immediately.
- Per-posedge priority, highest first:
  - clr: count<=RESET_VAL, tc<=0, ovf<=0.
  - load: count<=min(load_val, MAX_VAL), tc<=0, ovf unchanged.
  - en: step as below.
  - Otherwise: hold count, tc<=0.
- Arithmetic is performed in WIDTH+1 bits so that count+STEP never overflows internally.
- Up step:
  - If count+STEP <= MAX_VAL: count<=count+STEP, tc<=0.
  - Else, wrap mode: count<=count+STEP-(MAX_VAL+1), tc<=1, ovf<=1.
  - Else, saturate mode: count<=MAX_VAL, tc<=1, ovf<=1 only when count was not already MAX_VAL.
  - In saturate mode, holding at MAX_VAL with en=1 gives tc=0 and leaves ovf unchanged.
- Down step:
  - If count >= STEP: count<=count-STEP, tc<=0.
  - Else, wrap mode: count<=count+(MAX_VAL+1)-STEP, tc<=1, ovf<=1.
  - Else, saturate mode: count<=0, tc<=1 only when count was not already 0; ovf<=1 under the same condition.
- Latency:
  - count and tc update on the same posedge, so tc is high during the cycle in which count shows the post-crossing value.
  - tc stays high for exactly one cycle unless crossings occur on back-to-back enabled cycles.
- Direction may change every cycle with no dead cycle.
- Simultaneous clr+load+en: clr wins.
- load+en: load wins and no step is taken that cycle.
- Out-of-range count (> MAX_VAL) is unreachable by construction; load_val is clamped.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Decade wrap: WIDTH=4, MAX_VAL=9, STEP=1, SATURATE=0; from reset, en=1, up=1 for 12 clocks -> count sequence 1..9,0,1,2; tc high only while count=0 (10th clock); ovf=1 from clock 10; final count=2.
- Down wrap with step: WIDTH=8, MAX_VAL=99, STEP=7; load 3, then one down step -> count=96, tc=1, ovf=1.
- Saturate: WIDTH=8, MAX_VAL=200, SATURATE=1; load 198, en=1, up=1 for 4 clocks -> count 200,200,200,200; tc high only on the first clock.
  - Continue with up=0 for 201 clocks -> count reaches 0 with one tc pulse.
- Priority: assert clr, load and en together with load_val=5 -> count=RESET_VAL, ovf=0.
  - Then load=1, en=1, load_val=250 with MAX_VAL=200 -> count=200 (clamped), no step taken.
- Async reset: at count=37 assert rst_n low between clock edges -> count=RESET_VAL and tc=ovf=0 immediately.
  - Release rst_n; the first enabled up edge gives count=RESET_VAL+STEP.
- Override: two instances, one default and one with WIDTH=16, MAX_VAL=1000 set by defparam; run 1001 enabled up clocks -> default count=(1001 mod 256)=233 with ovf=1, wide count=0 with exactly one tc pulse.

Source files
------------

// File: rtl/counter_ext_if.sv
// Control and status bundle for counter_ext: the master drives the controls,
// the counter (slave) returns count, tc and ovf.
interface counter_ext_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tc, ovf
  );
endinterface

// File: rtl/counter_ext.sv
// Parametrised up/down counter with programmable modulus, wrap or saturate mode,
// a registered terminal-count pulse and a sticky overflow flag.
module counter_ext #(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = 255,
  parameter int RESET_VAL = 0,
  parameter int STEP      = 1,
  parameter int SATURATE  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  counter_ext_if.slave  bus
);

  // One extra bit so count+STEP and count+MAX_VAL+1 never overflow.
  typedef logic [WIDTH:0] ext_t;

  localparam ext_t             MAX_EXT   = ext_t'(MAX_VAL);
  localparam ext_t             MOD_EXT   = ext_t'(MAX_VAL + 1);
  localparam ext_t             STEP_EXT  = ext_t'(STEP);
  localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  ext_t             count_ext;
  ext_t             sum_ext;

  always_comb begin
    count_ext = {1'b0, count_q};
    sum_ext   = count_ext + STEP_EXT;
    count_d   = count_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;

    if (bus.clr) begin
      count_d = RESET_CNT;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} > MAX_EXT) begin
        count_d = MAX_CNT;
      end else begin
        count_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (sum_ext <= MAX_EXT) begin
          count_d = WIDTH'(sum_ext);
        end else if (SATURATE == 0) begin
          count_d = WIDTH'(sum_ext - MOD_EXT);
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          // Sitting at the ceiling is not a new crossing.
          count_d = MAX_CNT;
          if (count_q != MAX_CNT) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end
        end
      end else begin
        if (count_ext >= STEP_EXT) begin
          count_d = WIDTH'(count_ext - STEP_EXT);
        end else if (SATURATE == 0) begin
          count_d = WIDTH'(count_ext + MOD_EXT - STEP_EXT);
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = '0;
          if (count_q != '0) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_CNT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_ext.sv
// Directed checks of counter_ext across wrap, saturate, priority, async reset
// and parameter-override configurations, all sharing one clock and reset.
module tb_counter_ext;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  counter_ext_if #(.WIDTH(4))  dec_if ();
  counter_ext_if #(.WIDTH(8))  dn_if ();
  counter_ext_if #(.WIDTH(8))  sat_if ();
  counter_ext_if #(.WIDTH(8))  def_if ();
  counter_ext_if #(.WIDTH(16)) wide_if ();

  counter_ext #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .STEP(1), .SATURATE(0))
    u_dec (.clk(clk), .rst_n(rst_n), .bus(dec_if));

  counter_ext #(.WIDTH(8), .MAX_VAL(99), .RESET_VAL(0), .STEP(7), .SATURATE(0))
    u_dn (.clk(clk), .rst_n(rst_n), .bus(dn_if));

  counter_ext #(.WIDTH(8), .MAX_VAL(200), .RESET_VAL(10), .STEP(3), .SATURATE(1))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(sat_if));

  counter_ext u_def (.clk(clk), .rst_n(rst_n), .bus(def_if));

  counter_ext u_wide (.clk(clk), .rst_n(rst_n), .bus(wide_if));
  defparam u_wide.WIDTH   = 16;
  defparam u_wide.MAX_VAL = 1000;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int exp_cnt;
    int pulses;
    int def_pulses;
    int wide_pulses;

    {dec_if.en, dec_if.up, dec_if.clr, dec_if.load, dec_if.load_val} = '0;
    {dn_if.en, dn_if.up, dn_if.clr, dn_if.load, dn_if.load_val}     = '0;
    {sat_if.en, sat_if.up, sat_if.clr, sat_if.load, sat_if.load_val} = '0;
    {def_if.en, def_if.up, def_if.clr, def_if.load, def_if.load_val} = '0;
    {wide_if.en, wide_if.up, wide_if.clr, wide_if.load, wide_if.load_val} = '0;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_dec_count", dec_if.count, 0);
    checkOutput("reset_dec_tc", dec_if.tc, 0);
    checkOutput("reset_dec_ovf", dec_if.ovf, 0);
    checkOutput("reset_sat_count", sat_if.count, 10);
    checkOutput("reset_wide_count", wide_if.count, 0);

    @(negedge clk);
    rst_n     = 1'b1;
    dec_if.en = 1'b1;
    dec_if.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("dec_count_%0d", i), dec_if.count, i % 10);
      checkOutput($sformatf("dec_tc_%0d", i), dec_if.tc, (i == 10));
      checkOutput($sformatf("dec_ovf_%0d", i), dec_if.ovf, (i >= 10));
    end
    dec_if.en = 1'b0;

    dn_if.load     = 1'b1;
    dn_if.load_val = 8'd3;
    applyStimulus(1);
    checkOutput("dn_load", dn_if.count, 3);
    dn_if.load = 1'b0;
    dn_if.en   = 1'b1;
    dn_if.up   = 1'b0;
    applyStimulus(1);
    checkOutput("dn_wrap_count", dn_if.count, 96);
    checkOutput("dn_wrap_tc", dn_if.tc, 1);
    checkOutput("dn_wrap_ovf", dn_if.ovf, 1);
    applyStimulus(1);
    checkOutput("dn_step_count", dn_if.count, 89);
    checkOutput("dn_step_tc", dn_if.tc, 0);
    checkOutput("dn_sticky_ovf", dn_if.ovf, 1);
    dn_if.en = 1'b0;

    sat_if.load     = 1'b1;
    sat_if.load_val = 8'd198;
    applyStimulus(1);
    checkOutput("sat_load", sat_if.count, 198);
    sat_if.load = 1'b0;
    sat_if.en   = 1'b1;
    sat_if.up   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("sat_up_count_%0d", i), sat_if.count, 200);
      checkOutput($sformatf("sat_up_tc_%0d", i), sat_if.tc, (i == 0));
      checkOutput($sformatf("sat_up_ovf_%0d", i), sat_if.ovf, 1);
    end
    sat_if.up = 1'b0;
    exp_cnt   = 200;
    pulses    = 0;
    for (int i = 0; i < 201; i++) begin
      applyStimulus(1);
      exp_cnt = (exp_cnt >= 3) ? exp_cnt - 3 : 0;
      checkOutput($sformatf("sat_dn_count_%0d", i), sat_if.count, exp_cnt);
      if (sat_if.tc) pulses++;
    end
    checkOutput("sat_dn_pulses", pulses, 1);

    sat_if.clr      = 1'b1;
    sat_if.load     = 1'b1;
    sat_if.en       = 1'b1;
    sat_if.up       = 1'b1;
    sat_if.load_val = 8'd5;
    applyStimulus(1);
    checkOutput("prio_clr_count", sat_if.count, 10);
    checkOutput("prio_clr_ovf", sat_if.ovf, 0);
    checkOutput("prio_clr_tc", sat_if.tc, 0);
    sat_if.clr      = 1'b0;
    sat_if.load_val = 8'd250;
    applyStimulus(1);
    checkOutput("prio_clamp_count", sat_if.count, 200);
    checkOutput("prio_clamp_ovf", sat_if.ovf, 0);
    sat_if.load_val = 8'd50;
    applyStimulus(1);
    checkOutput("prio_load_no_step", sat_if.count, 50);
    sat_if.load = 1'b0;
    sat_if.en   = 1'b0;

    def_if.en   = 1'b1;
    def_if.up   = 1'b1;
    wide_if.en  = 1'b1;
    wide_if.up  = 1'b1;
    def_pulses  = 0;
    wide_pulses = 0;
    for (int i = 0; i < 1001; i++) begin
      applyStimulus(1);
      if (def_if.tc) def_pulses++;
      if (wide_if.tc) wide_pulses++;
    end
    checkOutput("ovr_def_count", def_if.count, 233);
    checkOutput("ovr_def_ovf", def_if.ovf, 1);
    checkOutput("ovr_def_pulses", def_pulses, 3);
    checkOutput("ovr_wide_count", wide_if.count, 0);
    checkOutput("ovr_wide_tc", wide_if.tc, 1);
    checkOutput("ovr_wide_ovf", wide_if.ovf, 1);
    checkOutput("ovr_wide_pulses", wide_pulses, 1);
    def_if.en  = 1'b0;
    wide_if.en = 1'b0;

    def_if.load     = 1'b1;
    def_if.load_val = 8'd37;
    applyStimulus(1);
    checkOutput("async_pre_count", def_if.count, 37);
    checkOutput("async_pre_ovf", def_if.ovf, 1);
    def_if.load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_count", def_if.count, 0);
    checkOutput("async_tc", def_if.tc, 0);
    checkOutput("async_ovf", def_if.ovf, 0);
    checkOutput("async_sat_count", sat_if.count, 10);
    @(negedge clk);
    rst_n     = 1'b1;
    def_if.en = 1'b1;
    def_if.up = 1'b1;
    applyStimulus(1);
    checkOutput("async_release_step", def_if.count, 1);
    def_if.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
